// File: rtl/ray_coord_scheduler.sv
// Raster coordinate issuer for the ray-march unit: walks the screen, issues one
// fixed-point (x, y) per credit-backed slot, drains at end of frame, pulses frame_done.
module ray_coord_scheduler #(
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter logic [31:0] COORD_STEP   = 32'h00200000,
  parameter int          MAX_INFLIGHT = 16,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_gen,
  input  logic             enable,
  input  logic             ds_ready,
  input  logic             retire,
  output logic [31:0]      screen_x,
  output logic [31:0]      screen_y,
  output logic             coord_valid,
  output logic             sof_tag,
  output logic             eol_tag,
  output logic             frame_done,
  output logic [CNT_W-1:0] inflight,
  output logic             busy,
  output logic             err_underflow
);
  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [XW-1:0]    X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(SCREEN_H - 1);
  localparam logic [CNT_W-1:0] MAX_Q  = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_idx_q, x_idx_d;
  logic [YW-1:0]     y_idx_q, y_idx_d;
  logic [31:0]       x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [31:0]       screen_x_q, screen_x_d, screen_y_q, screen_y_d;
  logic              coord_valid_q, coord_valid_d, sof_q, sof_d, eol_q, eol_d;
  logic              frame_done_q, frame_done_d, err_q, err_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              issue, underflow;

  always_comb begin
    state_d       = state_q;
    x_idx_d       = x_idx_q;
    y_idx_d       = y_idx_q;
    x_acc_d       = x_acc_q;
    y_acc_d       = y_acc_q;
    screen_x_d    = screen_x_q;
    screen_y_d    = screen_y_q;
    coord_valid_d = 1'b0;
    sof_d         = 1'b0;
    eol_d         = 1'b0;
    frame_done_d  = 1'b0;
    issue         = (state_q == RUN) && ds_ready && (inflight_q < MAX_Q);
    underflow     = retire && (inflight_q == '0);
    err_d         = err_q | underflow;

    // Credit counter: a retire against zero credits is absorbed and flagged.
    inflight_d = inflight_q;
    if (issue && !retire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!issue && retire) inflight_d = underflow ? '0 : inflight_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          x_idx_d = '0;
          y_idx_d = '0;
          x_acc_d = '0;
          y_acc_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          coord_valid_d = 1'b1;
          screen_x_d    = x_acc_q;
          screen_y_d    = y_acc_q;
          sof_d         = (x_idx_q == '0) && (y_idx_q == '0);
          eol_d         = (x_idx_q == X_LAST);
          if (x_idx_q != X_LAST) begin
            x_idx_d = x_idx_q + XW'(1);
            x_acc_d = x_acc_q + COORD_STEP;
          end else begin
            x_idx_d = '0;
            x_acc_d = '0;
            if (y_idx_q != Y_LAST) begin
              y_idx_d = y_idx_q + YW'(1);
              y_acc_d = y_acc_q + COORD_STEP;
            end else begin
              y_idx_d = '0;
              y_acc_d = '0;
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // inflight_d already folds in a retire landing this cycle.
        if (inflight_d == '0) begin
          frame_done_d = 1'b1;
          state_d      = enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_gen) begin
      state_q       <= IDLE;
      x_idx_q       <= '0;
      y_idx_q       <= '0;
      x_acc_q       <= '0;
      y_acc_q       <= '0;
      screen_x_q    <= '0;
      screen_y_q    <= '0;
      coord_valid_q <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      inflight_q    <= '0;
    end else begin
      state_q       <= state_d;
      x_idx_q       <= x_idx_d;
      y_idx_q       <= y_idx_d;
      x_acc_q       <= x_acc_d;
      y_acc_q       <= y_acc_d;
      screen_x_q    <= screen_x_d;
      screen_y_q    <= screen_y_d;
      coord_valid_q <= coord_valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      inflight_q    <= inflight_d;
    end
  end

  assign screen_x      = screen_x_q;
  assign screen_y      = screen_y_q;
  assign coord_valid   = coord_valid_q;
  assign sof_tag       = sof_q;
  assign eol_tag       = eol_q;
  assign frame_done    = frame_done_q;
  assign inflight      = inflight_q;
  assign busy          = (state_q != IDLE);
  assign err_underflow = err_q;
endmodule

// File: tb/tb_ray_coord_scheduler.sv
// Bench for ray_coord_scheduler: a 4x2 screen on two instances (16 and 2 credits),
// raster order checked through a per-instance expected-strobe queue.
module tb_ray_coord_scheduler;
  localparam logic [31:0] STEP = 32'h00200000;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sof;
    logic        eol;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance A: 16 credits
  logic        a_rst, a_en, a_rdy, a_ret, a_ret_man, a_echo_en, echo_ret;
  logic [31:0] a_sx, a_sy;
  logic        a_cv, a_sof, a_eol, a_fd, a_busy, a_err;
  logic [7:0]  a_inf;
  // Instance B: 2 credits
  logic        b_rst, b_en, b_rdy, b_ret;
  logic [31:0] b_sx, b_sy;
  logic        b_cv, b_sof, b_eol, b_fd, b_busy, b_err;
  logic [7:0]  b_inf;

  ray_coord_scheduler #(.SCREEN_W(4), .SCREEN_H(2), .COORD_STEP(STEP),
                        .MAX_INFLIGHT(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst_gen(a_rst), .enable(a_en), .ds_ready(a_rdy), .retire(a_ret),
    .screen_x(a_sx), .screen_y(a_sy), .coord_valid(a_cv), .sof_tag(a_sof),
    .eol_tag(a_eol), .frame_done(a_fd), .inflight(a_inf), .busy(a_busy),
    .err_underflow(a_err));

  ray_coord_scheduler #(.SCREEN_W(4), .SCREEN_H(2), .COORD_STEP(STEP),
                        .MAX_INFLIGHT(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_gen(b_rst), .enable(b_en), .ds_ready(b_rdy), .retire(b_ret),
    .screen_x(b_sx), .screen_y(b_sy), .coord_valid(b_cv), .sof_tag(b_sof),
    .eol_tag(b_eol), .frame_done(b_fd), .inflight(b_inf), .busy(b_busy),
    .err_underflow(b_err));

  // Retire echo: each A strobe comes back as a retire 3 cycles later.
  logic [3:0] hist = '0;
  always @(posedge clk) begin
    #1;
    hist = {hist[2:0], a_cv};
    echo_ret = hist[3];
  end
  assign a_ret = a_echo_en ? echo_ret : a_ret_man;

  exp_t qa[$];
  exp_t qb[$];
  int a_strobes = 0, b_strobes = 0;
  int a_first = 0, a_last = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_cv === 1'b1) begin
      n_chk++;
      if (a_strobes == 0) a_first = cyc;
      a_last = cyc;
      a_strobes++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_strobe: got x=%h y=%h, required no strobe", a_sx, a_sy);
      end else begin
        e = qa.pop_front();
        if (a_sx !== e.x || a_sy !== e.y || a_sof !== e.sof || a_eol !== e.eol) begin
          n_fail++;
          $display("FAIL a_strobe: got x=%h y=%h sof=%b eol=%b, required x=%h y=%h sof=%b eol=%b",
                   a_sx, a_sy, a_sof, a_eol, e.x, e.y, e.sof, e.eol);
        end
      end
    end
    if (b_cv === 1'b1) begin
      n_chk++;
      b_strobes++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_strobe: got x=%h y=%h, required no strobe", b_sx, b_sy);
      end else begin
        e = qb.pop_front();
        if (b_sx !== e.x || b_sy !== e.y || b_sof !== e.sof || b_eol !== e.eol) begin
          n_fail++;
          $display("FAIL b_strobe: got x=%h y=%h sof=%b eol=%b, required x=%h y=%h sof=%b eol=%b",
                   b_sx, b_sy, b_sof, b_eol, e.x, e.y, e.sof, e.eol);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input bit to_b);
    exp_t e;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) begin
        e.x   = 32'(x) * STEP;
        e.y   = 32'(y) * STEP;
        e.sof = (x == 0 && y == 0);
        e.eol = (x == 3);
        if (to_b) qb.push_back(e); else qa.push_back(e);
      end
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; a_en = 0; a_rdy = 0; a_ret_man = 0; a_echo_en = 0;
    b_en = 0; b_rdy = 0; b_ret = 0;
    step(); step();
    n_chk++;
    if ({a_cv, a_sof, a_eol, a_fd, a_busy, a_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000000", {a_cv, a_sof, a_eol, a_fd, a_busy, a_err});
    end
    n_chk++;
    if (a_inf !== 8'd0 || a_sx !== 32'd0 || a_sy !== 32'd0) begin
      n_fail++; $display("FAIL reset_values: got inf=%0d x=%h y=%h, required 0 0 0", a_inf, a_sx, a_sy);
    end
    n_chk++;
    if (b_inf !== 8'd0 || b_busy !== 1'b0 || b_cv !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got inf=%0d busy=%b cv=%b, required 0 0 0", b_inf, b_busy, b_cv);
    end
    a_rst = 0; b_rst = 0;
    step();
  endtask

  task automatic test_frame();
    logic prev_ret, prev_inf1;
    bit   seen;
    push_frame(0);
    a_echo_en = 1; a_rdy = 1; a_en = 1;
    prev_ret = 0; prev_inf1 = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (a_fd === 1'b1) begin
        seen = 1;
        n_chk++;
        if (prev_ret !== 1'b1 || prev_inf1 !== 1'b1) begin
          n_fail++; $display("FAIL frame_done_timing: got prev_retire=%b prev_inflight_is_1=%b, required 1 1", prev_ret, prev_inf1);
        end
      end
      prev_ret = a_ret;
      prev_inf1 = (a_inf == 8'd1);
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL frame_done_timeout: got none, required a pulse"); end
    n_chk++;
    if (a_strobes != 8 || a_last - a_first != 7) begin
      n_fail++; $display("FAIL frame_throughput: got %0d strobes over span %0d, required 8 over 7", a_strobes, a_last - a_first);
    end
    push_frame(0);
    step();
    n_chk++;
    if (a_cv !== 1'b1 || a_sof !== 1'b1) begin
      n_fail++; $display("FAIL restart_sof: got cv=%b sof=%b, required 1 1", a_cv, a_sof);
    end
  endtask

  task automatic test_enable_drop();
    bit seen = 0;
    for (int i = 0; i < 20 && a_strobes < 11; i++) step();
    a_en = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (a_fd === 1'b1) seen = 1;
    end
    n_chk++;
    if (!seen || a_strobes != 16) begin
      n_fail++; $display("FAIL enable_drop_completion: got done=%b strobes=%0d, required 1 16", seen, a_strobes);
    end
    step(); step(); step();
    n_chk++;
    if (a_busy !== 1'b0 || a_strobes != 16 || a_inf !== 8'd0) begin
      n_fail++; $display("FAIL enable_drop_idle: got busy=%b strobes=%0d inf=%0d, required 0 16 0", a_busy, a_strobes, a_inf);
    end
  endtask

  task automatic test_ds_toggle();
    int  base = a_strobes;
    int  bad = 0;
    logic prev_rdy;
    push_frame(0);
    a_en = 1; a_rdy = 1; prev_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (i == 0) a_en = 0;
      if (a_cv === 1'b1 && prev_rdy !== 1'b1) bad++;
      a_rdy = ~a_rdy;
      prev_rdy = a_rdy;
    end
    n_chk++;
    if (bad != 0 || a_strobes - base != 8) begin
      n_fail++; $display("FAIL ds_toggle: got strobes=%0d off_ready=%0d, required 8 0", a_strobes - base, bad);
    end
    a_rdy = 1;
    for (int i = 0; i < 30 && a_busy !== 1'b0; i++) step();
    n_chk++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ds_toggle_idle: got busy=%b, required 0", a_busy); end
  endtask

  task automatic test_credit();
    push_frame(1);
    b_rdy = 1; b_ret = 0; b_en = 1;
    repeat (10) step();
    n_chk++;
    if (b_strobes != 2 || b_inf !== 8'd2 || b_cv !== 1'b0) begin
      n_fail++; $display("FAIL credit_stall: got strobes=%0d inf=%0d cv=%b, required 2 2 0", b_strobes, b_inf, b_cv);
    end
    b_ret = 1;
    step();
    b_ret = 0;
    n_chk++;
    if (b_inf !== 8'd1 || b_cv !== 1'b0) begin
      n_fail++; $display("FAIL credit_retire: got inf=%0d cv=%b, required 1 0", b_inf, b_cv);
    end
    step();
    n_chk++;
    if (b_cv !== 1'b1 || b_inf !== 8'd2 || b_strobes != 3) begin
      n_fail++; $display("FAIL credit_reissue: got cv=%b inf=%0d strobes=%0d, required 1 2 3", b_cv, b_inf, b_strobes);
    end
    repeat (4) step();
    n_chk++;
    if (b_strobes != 3) begin n_fail++; $display("FAIL credit_single: got strobes=%0d, required 3", b_strobes); end
  endtask

  task automatic test_simul_issue_retire();
    b_ret = 1;
    step();
    n_chk++;
    if (b_inf !== 8'd1) begin n_fail++; $display("FAIL simul_setup: got inf=%0d, required 1", b_inf); end
    step();
    b_ret = 0; b_rdy = 0;
    n_chk++;
    if (b_inf !== 8'd1 || b_cv !== 1'b1 || b_strobes != 4) begin
      n_fail++; $display("FAIL simul_issue_retire: got inf=%0d cv=%b strobes=%0d, required 1 1 4", b_inf, b_cv, b_strobes);
    end
    n_chk++;
    if (b_err !== 1'b0) begin n_fail++; $display("FAIL b_no_underflow: got err=%b, required 0", b_err); end
    b_en = 0; b_rst = 1;
    step();
    b_rst = 0;
    qb.delete();
  endtask

  task automatic test_reset_midframe();
    int fd_seen = 0;
    a_echo_en = 0; a_ret_man = 0;
    push_frame(0);
    a_en = 1; a_rdy = 1;
    step();
    a_en = 0;
    step(); step(); step();
    a_rdy = 0;
    n_chk++;
    if (a_inf !== 8'd3) begin n_fail++; $display("FAIL midframe_setup: got inf=%0d, required 3", a_inf); end
    a_rst = 1;
    step();
    a_rst = 0;
    qa.delete();
    n_chk++;
    if (a_inf !== 8'd0 || a_busy !== 1'b0 || a_cv !== 1'b0 || a_fd !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reset: got inf=%0d busy=%b cv=%b fd=%b, required 0 0 0 0", a_inf, a_busy, a_cv, a_fd);
    end
    repeat (4) begin
      step();
      if (a_fd === 1'b1) fd_seen++;
    end
    n_chk++;
    if (fd_seen != 0) begin n_fail++; $display("FAIL midframe_no_done: got %0d pulses, required 0", fd_seen); end
    a_ret_man = 1;
    step();
    a_ret_man = 0;
    n_chk++;
    if (a_err !== 1'b1 || a_inf !== 8'd0) begin
      n_fail++; $display("FAIL underflow: got err=%b inf=%0d, required 1 0", a_err, a_inf);
    end
    step(); step();
    n_chk++;
    if (a_err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got err=%b, required 1", a_err); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_enable_drop();
    test_ds_toggle();
    test_credit();
    test_simul_issue_retire();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
